// File: rtl/energy_calc_ctrl.sv
// energy_calc_ctrl: walks every spin index once, fetching its weight row
// and accumulating the per-spin local energy into a signed total.
//
// Ports:
//   clk_i, rst_i              clock, async active-high reset
//   spin_valid_i/ready_o      spin vector handshake, spin_i payload
//   weight_ren_o/raddr_o      one-cycle row read request and row index
//   weight_rvalid_i           row data valid; local_energy_i is then valid
//   calc_spin_o               latched spin vector to the datapath
//   calc_current_spin_o       latched spin bit at the current index
//   energy_o/valid_o/ready_i  total energy handshake
//   busy_o                    high whenever not idle
module energy_calc_ctrl #(
  parameter int DATASPIN         = 256,
  parameter int LOCAL_ENERGY_BIT = 16,
  parameter int ENERGY_TOTAL_BIT = 32,
  parameter int ADDRW            =
    (DATASPIN > 1) ? $clog2(DATASPIN) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               spin_valid_i,
  output logic                               spin_ready_o,
  input  logic [DATASPIN-1:0]                spin_i,
  output logic                               weight_ren_o,
  output logic [ADDRW-1:0]                   weight_raddr_o,
  input  logic                               weight_rvalid_i,
  output logic [DATASPIN-1:0]                calc_spin_o,
  output logic                               calc_current_spin_o,
  input  logic signed [LOCAL_ENERGY_BIT-1:0] local_energy_i,
  output logic signed [ENERGY_TOTAL_BIT-1:0] energy_o,
  output logic                               energy_valid_o,
  input  logic                               energy_ready_i,
  output logic                               busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  localparam logic [ADDRW-1:0] LAST_IDX =
    ADDRW'(DATASPIN - 1);

  state_t                             state;
  logic [ADDRW-1:0]                   idx;
  logic [DATASPIN-1:0]                spin_q;
  logic signed [ENERGY_TOTAL_BIT-1:0] acc;
  logic signed [ENERGY_TOTAL_BIT-1:0] le_ext;
  logic signed [ENERGY_TOTAL_BIT-1:0] acc_sum;

  // Size cast of a signed operand sign-extends the local energy.
  assign le_ext  = ENERGY_TOTAL_BIT'(local_energy_i);
  assign acc_sum = acc + le_ext;

  assign calc_spin_o         = spin_q;
  assign calc_current_spin_o = spin_q[idx];
  assign weight_raddr_o      = idx;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      idx            <= '0;
      acc            <= '0;
      spin_q         <= '0;
      weight_ren_o   <= 1'b0;
      energy_o       <= '0;
      energy_valid_o <= 1'b0;
      busy_o         <= 1'b0;
      spin_ready_o   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          spin_ready_o <= 1'b1;
          if (spin_valid_i && spin_ready_o) begin
            spin_q       <= spin_i;
            idx          <= '0;
            acc          <= '0;
            weight_ren_o <= 1'b1;
            busy_o       <= 1'b1;
            spin_ready_o <= 1'b0;
            state        <= REQ;
          end
        end
        REQ: begin
          weight_ren_o <= 1'b0;
          state        <= WAIT;
        end
        WAIT: begin
          if (weight_rvalid_i) begin
            acc <= acc_sum;
            if (idx == LAST_IDX) begin
              // Publish the final sum directly so it
              // appears together with valid.
              energy_o       <= acc_sum;
              energy_valid_o <= 1'b1;
              state          <= DONE;
            end else begin
              idx          <= idx + 1'b1;
              weight_ren_o <= 1'b1;
              state        <= REQ;
            end
          end
        end
        DONE: begin
          if (energy_ready_i) begin
            energy_valid_o <= 1'b0;
            busy_o         <= 1'b0;
            spin_ready_o   <= 1'b1;
            state          <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_energy_calc_ctrl.sv
// tb_energy_calc_ctrl: table-driven and randomized checks of
// energy_calc_ctrl against a sum-of-energies reference model.
module tb_energy_calc_ctrl;

  localparam int N  = 4;
  localparam int NB = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic               sv, sr, ren, rv, cs_bit, ev, er, busy;
  logic [N-1:0]       sp, cs;
  logic [1:0]         ra;
  logic signed [15:0] le;
  logic signed [31:0] en;

  logic               b_sv, b_sr, b_ren, b_rv, b_csb, b_ev, b_er, b_busy;
  logic [NB-1:0]      b_sp, b_cs;
  logic [7:0]         b_ra;
  logic signed [15:0] b_le;
  logic signed [31:0] b_en;

  int checks = 0;
  int fails  = 0;

  energy_calc_ctrl #(.DATASPIN(N)) u_dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .spin_valid_i       (sv),
    .spin_ready_o       (sr),
    .spin_i             (sp),
    .weight_ren_o       (ren),
    .weight_raddr_o     (ra),
    .weight_rvalid_i    (rv),
    .calc_spin_o        (cs),
    .calc_current_spin_o(cs_bit),
    .local_energy_i     (le),
    .energy_o           (en),
    .energy_valid_o     (ev),
    .energy_ready_i     (er),
    .busy_o             (busy)
  );

  energy_calc_ctrl #(.DATASPIN(NB)) u_big (
    .clk_i              (clk),
    .rst_i              (rst),
    .spin_valid_i       (b_sv),
    .spin_ready_o       (b_sr),
    .spin_i             (b_sp),
    .weight_ren_o       (b_ren),
    .weight_raddr_o     (b_ra),
    .weight_rvalid_i    (b_rv),
    .calc_spin_o        (b_cs),
    .calc_current_spin_o(b_csb),
    .local_energy_i     (b_le),
    .energy_o           (b_en),
    .energy_valid_o     (b_ev),
    .energy_ready_i     (b_er),
    .busy_o             (b_busy)
  );

  typedef struct {
    logic [N-1:0] spins;
    int           lat[N];
    int           le[N];
    int           want;
    int           hold;
    bit           spur;
    bit           b2b;
    logic [N-1:0] nxt;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name,
                     input logic signed [63:0] a,
                     input logic signed [63:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one computation on the 4-spin DUT and checks it against
  // the model: total = plain sum, valid at 1 + sum(1 + latency).
  task automatic calc(input vec_t v, output int res);
    int pend, k, cyc, pulses, nwait, prev_ren, want_cyc;
    logic signed [31:0] held;
    pend = 0; k = 0; pulses = 0; nwait = 0; prev_ren = 0;
    want_cyc = 1;
    for (int i = 0; i < N; i++) want_cyc += 1 + v.lat[i];
    rv = v.spur; le = 16'sh7fff; er = 1'b0;
    sv = 1'b1; sp = v.spins;
    while (sr !== 1'b1 && nwait < 20) begin
      tick(); nwait++;
    end
    chk("accept_wait", nwait, 0);
    tick();
    sv = 1'b0; sp = 4'($urandom);
    chk("busy_after_accept", busy, 1);
    chk("ready_after_accept", sr, 0);
    chk("calc_spin", cs, v.spins);
    cyc = 1;
    while (ev !== 1'b1 && cyc < 200) begin
      rv = 1'b0; le = 16'($urandom);
      if (pend > 0) begin
        pend--;
        if (pend == 0 && k < N) begin
          rv = 1'b1; le = 16'(v.le[k]); k++;
        end
      end
      if (ren === 1'b1) begin
        chk("ren_width", prev_ren, 0);
        if (pulses < N) begin
          chk("ren_addr", ra, pulses);
          chk("cur_spin", cs_bit, v.spins[pulses]);
          pend = v.lat[pulses];
        end
        pulses++;
        if (v.spur) begin
          rv = 1'b1; le = 16'sh7fff;
        end
      end
      prev_ren = (ren === 1'b1) ? 1 : 0;
      tick(); cyc++;
    end
    chk("valid_cycle", cyc, want_cyc);
    chk("ren_pulses", pulses, N);
    chk("energy", en, v.want);
    held = en;
    rv = v.spur; le = 16'sh7fff;
    for (int i = 0; i < v.hold; i++) begin
      if (v.b2b) begin
        sv = 1'b1; sp = v.nxt;
      end
      tick();
      chk("hold_valid", ev, 1);
      chk("hold_energy", en, held);
      chk("hold_ready", sr, 0);
      chk("hold_spin", cs, v.spins);
    end
    er = 1'b1;
    tick();
    er = 1'b0;
    chk("valid_drop", ev, 0);
    chk("energy_keep", en, held);
    chk("ready_idle", sr, 1);
    chk("busy_idle", busy, 0);
    res = int'(held);
  endtask

  initial begin
    int r1, r2, n, p, cyc, pulses, bad;
    vec_t v;

    tbl[0] = '{spins:4'b1010, lat:'{1,1,1,1}, le:'{3,-5,7,-1},
               want:4, hold:0, spur:0, b2b:0, nxt:4'b0};
    tbl[1] = '{spins:4'b1010, lat:'{3,5,1,2}, le:'{3,-5,7,-1},
               want:4, hold:1, spur:1, b2b:0, nxt:4'b0};
    tbl[2] = '{spins:4'b0101, lat:'{1,2,1,1},
               le:'{100,-200,300,-400},
               want:-200, hold:10, spur:1, b2b:1, nxt:4'b0101};
    tbl[3] = '{spins:4'b1111, lat:'{1,1,1,1}, le:'{1,2,3,4},
               want:10, hold:3, spur:0, b2b:1, nxt:4'b0011};
    tbl[4] = '{spins:4'b0011, lat:'{2,1,4,1},
               le:'{-32768,-32768,32767,0},
               want:-32769, hold:0, spur:1, b2b:0, nxt:4'b0};

    rst = 1'b1;
    sv = 0; sp = '0; rv = 0; le = '0; er = 0;
    b_sv = 0; b_sp = '0; b_rv = 0; b_le = -16'sd32768; b_er = 0;
    tick(); tick();
    chk("rst_ready", sr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", ev, 0);
    chk("rst_energy", en, 0);
    chk("rst_ren", ren, 0);
    chk("rst_addr", ra, 0);
    chk("rst_spin", cs, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) calc(tbl[i], r1);

    for (int it = 0; it < 12; it++) begin
      v.spins = 4'($urandom);
      v.want = 0;
      for (int i = 0; i < N; i++) begin
        v.lat[i] = int'($urandom_range(1, 5));
        v.le[i]  = int'($urandom_range(0, 65535)) - 32768;
        v.want  += v.le[i];
      end
      v.hold = int'($urandom_range(0, 3));
      v.spur = 1'b1; v.b2b = 1'b0; v.nxt = '0;
      calc(v, r1);
      for (int i = 0; i < N; i++) v.lat[i] = 1;
      v.spur = 1'b0;
      calc(v, r2);
      chk("lat_indep", r2, r1);
    end

    // Abort in WAIT of index 2, then a fresh computation.
    sv = 1'b1; sp = 4'b0110; le = 16'sd100; rv = 1'b0; p = 0;
    n = 0;
    while (sr !== 1'b1 && n < 10) begin
      tick(); n++;
    end
    tick();
    sv = 1'b0;
    n = 0;
    while (!(ren === 1'b1 && ra == 2'd2) && n < 20) begin
      rv = p[0]; p = (ren === 1'b1) ? 1 : 0;
      tick(); n++;
    end
    chk("pre_rst_addr", ra, 2);
    rv = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("abort_ren", ren, 0);
    chk("abort_addr", ra, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", sr, 0);
    chk("abort_valid", ev, 0);
    chk("abort_energy", en, 0);
    chk("abort_spin", cs, 0);
    tick();
    rst = 1'b0;
    tick();
    v = tbl[0];
    v.le = '{-7, 20, 5, -3};
    v.want = 15;
    calc(v, r1);

    // 256-spin run at minimum latency, every energy at the minimum.
    b_sv = 1'b1; b_sp = {8{$urandom}};
    n = 0;
    while (b_sr !== 1'b1 && n < 10) begin
      tick(); n++;
    end
    tick();
    b_sv = 1'b0;
    cyc = 1; p = 0; pulses = 0; bad = 0;
    while (b_ev !== 1'b1 && cyc < 2000) begin
      b_rv = p[0];
      p = (b_ren === 1'b1) ? 1 : 0;
      if (b_ren === 1'b1) begin
        if (b_ra != 8'(pulses)) bad++;
        pulses++;
      end
      tick(); cyc++;
    end
    b_rv = 1'b0;
    chk("big_energy", b_en, -8388608);
    chk("big_cycle", cyc, 2 * NB + 1);
    chk("big_pulses", pulses, NB);
    chk("big_addr_seq", bad, 0);
    b_er = 1'b1;
    tick();
    b_er = 1'b0;
    chk("big_valid_drop", b_ev, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
